// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the multi-channel command sequencer.
//   state_e             : sequencer FSM states
//   DefaultIdlePattern  : frame sent on every lane while no sequence is active
package cmd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StFinish
    } state_e;

    localparam logic [15:0] DefaultIdlePattern = 16'h817E;

endpackage

// File: rtl/cmd_seq_mem.sv
// Sequence memory: DEPTH x DATA_WIDTH, one write port, one read port with a
// registered read (1-cycle latency). Kept on its own so it can map to block RAM.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe; rd_data_o updates on the next edge and then holds
//   rd_addr_i  read address
//   rd_data_o  registered read data
module cmd_seq_mem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cmd_seq_mc.sv
// Multi-channel command sequencer. Serialises a programmed list of command
// words MSB first onto NUM_CH lanes, with repeat / endless-loop / stop control
// and a continuous frame-aligned idle pattern on every lane not carrying data.
// Ports:
//   BUS_CLK, BUS_RST        clock, synchronous active-high reset
//   WR_EN/WR_ADDR/WR_DATA   sequence-memory write (dropped with WR_ERR while BUSY)
//   START, STOP             single-cycle requests (STOP wins over START)
//   EXT_TRIGGER             start request, gated by EXT_START_EN
//   LENGTH, REPEAT          words per repetition, repetitions (0 = until STOP)
//   BIT_DIV                 each bit lasts BIT_DIV+1 cycles
//   CH_MASK                 per-lane select: sequence (1) or idle pattern (0)
//   OUT_EN_CFG / OUTPUT_EN  output-enable request and its registered copy
//   SERIAL_OUT              registered serial lanes
//   BUSY, WRITING           start pending or sequence active / data on lanes
//   LOOP_START, DONE        first-bit-of-repetition pulse / end-of-sequence pulse
//   WR_ERR                  pulse for a dropped write
module cmd_seq_mc
    import cmd_seq_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH   = 16,
    parameter int unsigned            DEPTH        = 256,
    parameter int unsigned            NUM_CH       = 4,
    parameter logic [DATA_WIDTH-1:0]  IDLE_PATTERN = DATA_WIDTH'(DefaultIdlePattern),
    localparam int unsigned           AW           = $clog2(DEPTH)
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic                  WR_EN,
    input  logic [AW-1:0]         WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  EXT_TRIGGER,
    input  logic                  EXT_START_EN,
    input  logic [AW:0]           LENGTH,
    input  logic [15:0]           REPEAT,
    input  logic [7:0]            BIT_DIV,
    input  logic [NUM_CH-1:0]     CH_MASK,
    input  logic                  OUT_EN_CFG,
    output logic [NUM_CH-1:0]     SERIAL_OUT,
    output logic                  OUTPUT_EN,
    output logic                  BUSY,
    output logic                  WRITING,
    output logic                  LOOP_START,
    output logic                  DONE,
    output logic                  WR_ERR
);

    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BitMsb = BW'(DATA_WIDTH - 1);

    // Bit timing
    logic [7:0]    div_cnt_q;
    logic [BW-1:0] bit_cnt_q;
    logic [7:0]    div_lim;
    logic          div_wrap;
    logic          word_bnd;

    // Control state
    state_e          state_q;
    logic            pending_q;
    logic            busy_q;
    logic            stop_q;
    logic            writing_q;
    logic            ls_q;
    logic [AW:0]     len_q;
    logic [15:0]     rep_q;
    logic [15:0]     rep_cnt_q;
    logic [7:0]      bit_div_q;
    logic [NUM_CH-1:0] mask_q;
    logic [AW-1:0]   addr_q;

    // Pad-side registers
    logic [NUM_CH-1:0] serial_q;
    logic              out_en_q;
    logic              writing_out_q;
    logic              loop_start_q;
    logic              done_q;
    logic              wr_err_q;

    logic            start_ok;
    logic            wr_ok;
    logic [AW:0]     last_addr;
    logic            last_word;
    logic            more_reps;
    logic            stop_now;
    logic            seq_end;
    logic [AW-1:0]   next_addr;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [NUM_CH-1:0] lane_d;

    assign start_ok = (START | (EXT_TRIGGER & EXT_START_EN)) & ~STOP & ~busy_q;
    assign wr_ok    = WR_EN & ~busy_q;

    // While idle the live divider drives the idle stream; once a start is
    // taken the latched copy (equal at that moment) keeps timing stable.
    assign div_lim  = busy_q ? bit_div_q : BIT_DIV;
    assign div_wrap = div_cnt_q >= div_lim;
    assign word_bnd = div_wrap & (bit_cnt_q == '0);

    assign last_addr = len_q - {{AW{1'b0}}, 1'b1};
    assign last_word = {1'b0, addr_q} == last_addr;
    assign more_reps = (rep_q == '0) | (rep_cnt_q != rep_q - 16'd1);
    assign stop_now  = stop_q | STOP;
    assign seq_end   = stop_now | (last_word & ~more_reps);
    assign next_addr = last_word ? '0 : addr_q + AW'(1);

    // Prefetch on the final cycle of each word so the registered read lands
    // exactly on the first bit of the next word.
    assign rd_en   = (state_q == StLoad) |
                     ((state_q == StShift) & writing_q & word_bnd & ~seq_end);
    assign rd_addr = (state_q == StLoad) ? '0 : next_addr;

    always_comb begin
        lane_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            lane_d[i] = (writing_q & mask_q[i]) ? rd_data[bit_cnt_q] : IDLE_PATTERN[bit_cnt_q];
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            div_cnt_q <= '0;
            bit_cnt_q <= BitMsb;
        end else if (div_wrap) begin
            div_cnt_q <= '0;
            bit_cnt_q <= (bit_cnt_q == '0) ? BitMsb : bit_cnt_q - BW'(1);
        end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q       <= StIdle;
            pending_q     <= 1'b0;
            busy_q        <= 1'b0;
            stop_q        <= 1'b0;
            writing_q     <= 1'b0;
            ls_q          <= 1'b0;
            len_q         <= '0;
            rep_q         <= '0;
            rep_cnt_q     <= '0;
            bit_div_q     <= '0;
            mask_q        <= '0;
            addr_q        <= '0;
            // Last bit of the previous idle frame; the next edge emits the MSB.
            serial_q      <= {NUM_CH{IDLE_PATTERN[0]}};
            out_en_q      <= 1'b0;
            writing_out_q <= 1'b0;
            loop_start_q  <= 1'b0;
            done_q        <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            ls_q          <= 1'b0;
            done_q        <= 1'b0;
            out_en_q      <= OUT_EN_CFG;
            wr_err_q      <= WR_EN & busy_q;
            serial_q      <= lane_d;
            writing_out_q <= writing_q;
            loop_start_q  <= ls_q;

            if (start_ok) begin
                pending_q <= 1'b1;
                busy_q    <= 1'b1;
                len_q     <= LENGTH;
                rep_q     <= REPEAT;
                bit_div_q <= BIT_DIV;
                mask_q    <= CH_MASK;
            end

            unique case (state_q)
                StIdle: begin
                    if (pending_q) begin
                        if (STOP) begin
                            pending_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else if (word_bnd) begin
                            pending_q <= 1'b0;
                            if (len_q == '0) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end else begin
                                state_q   <= StLoad;
                                addr_q    <= '0;
                                rep_cnt_q <= '0;
                                stop_q    <= 1'b0;
                            end
                        end
                    end
                end
                StLoad: begin
                    state_q <= StShift;
                    if (STOP) begin
                        stop_q <= 1'b1;
                    end
                end
                StShift: begin
                    if (STOP) begin
                        stop_q <= 1'b1;
                    end
                    if (word_bnd) begin
                        if (!writing_q) begin
                            // First word waits for a frame boundary to stay aligned.
                            if (stop_now) begin
                                state_q <= StFinish;
                            end else begin
                                writing_q <= 1'b1;
                                ls_q      <= 1'b1;
                            end
                        end else if (seq_end) begin
                            writing_q <= 1'b0;
                            state_q   <= StFinish;
                        end else if (last_word) begin
                            addr_q    <= '0;
                            rep_cnt_q <= rep_cnt_q + 16'd1;
                            ls_q      <= 1'b1;
                        end else begin
                            addr_q <= next_addr;
                        end
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    stop_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    cmd_seq_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk_i     (BUS_CLK),
        .wr_en_i   (wr_ok),
        .wr_addr_i (WR_ADDR),
        .wr_data_i (WR_DATA),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign SERIAL_OUT = serial_q;
    assign OUTPUT_EN  = out_en_q;
    assign BUSY       = busy_q;
    assign WRITING    = writing_out_q;
    assign LOOP_START = loop_start_q;
    assign DONE       = done_q;
    assign WR_ERR     = wr_err_q;

endmodule

// File: tb/tb_cmd_seq_mc.sv
// Self-checking bench for cmd_seq_mc: table of sequence scenarios with
// hand-derived lane streams, plus directed corner-case sequences.
module tb_cmd_seq_mc;

    localparam logic [15:0] IDLE = 16'h817E;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic        WR_EN;
    logic [7:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic        START;
    logic        STOP;
    logic        EXT_TRIGGER;
    logic        EXT_START_EN;
    logic [8:0]  LENGTH;
    logic [15:0] REPEAT;
    logic [7:0]  BIT_DIV;
    logic [3:0]  CH_MASK;
    logic        OUT_EN_CFG;
    logic [3:0]  SERIAL_OUT;
    logic        OUTPUT_EN;
    logic        BUSY;
    logic        WRITING;
    logic        LOOP_START;
    logic        DONE;
    logic        WR_ERR;

    cmd_seq_mc dut (
        .BUS_CLK      (BUS_CLK),
        .BUS_RST      (BUS_RST),
        .WR_EN        (WR_EN),
        .WR_ADDR      (WR_ADDR),
        .WR_DATA      (WR_DATA),
        .START        (START),
        .STOP         (STOP),
        .EXT_TRIGGER  (EXT_TRIGGER),
        .EXT_START_EN (EXT_START_EN),
        .LENGTH       (LENGTH),
        .REPEAT       (REPEAT),
        .BIT_DIV      (BIT_DIV),
        .CH_MASK      (CH_MASK),
        .OUT_EN_CFG   (OUT_EN_CFG),
        .SERIAL_OUT   (SERIAL_OUT),
        .OUTPUT_EN    (OUTPUT_EN),
        .BUSY         (BUSY),
        .WRITING      (WRITING),
        .LOOP_START   (LOOP_START),
        .DONE         (DONE),
        .WR_ERR       (WR_ERR)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          len;
        int          reps;
        int          div;
        logic [3:0]  mask;
        bit          ext;
        bit          wws;       // write word 1 in the same cycle as the start
        bit          do_write;
        bit          wr_busy;   // attempt a write to address 0 while running
        int          stop_word; // -1: no STOP
    } scen_t;

    scen_t tbl[5];
    int checks = 0;
    int errors = 0;
    int k = 0;

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
        k++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at sample %0d: got %h, expected %h", name, k, act, exp);
        end
    endtask

    function automatic logic idle_bit(input int j, input int d);
        logic [15:0] p;
        int pos;
        p   = IDLE;
        pos = 15 - (((j - 1) / (d + 1)) % 16);
        return p[pos];
    endfunction

    task automatic samp(input logic [3:0] lanes, input logic wr, input logic ls,
                        input logic dn, input logic bz, input logic we);
        chk("lanes", 32'(SERIAL_OUT), 32'(lanes));
        chk("writing", 32'(WRITING), 32'(wr));
        chk("loop_start", 32'(LOOP_START), 32'(ls));
        chk("done", 32'(DONE), 32'(dn));
        chk("busy", 32'(BUSY), 32'(bz));
        chk("wr_err", 32'(WR_ERR), 32'(we));
        chk("output_en", 32'(OUTPUT_EN), 32'(1));
    endtask

    task automatic idle_samp(input int d, input logic bz);
        samp({4{idle_bit(k, d)}}, 1'b0, 1'b0, 1'b0, bz, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_lanes"}, 32'(SERIAL_OUT), 32'({4{IDLE[0]}}));
        chk({tag, "_busy"}, 32'(BUSY), 32'(0));
        chk({tag, "_writing"}, 32'(WRITING), 32'(0));
        chk({tag, "_done"}, 32'(DONE), 32'(0));
        chk({tag, "_loop_start"}, 32'(LOOP_START), 32'(0));
        chk({tag, "_wr_err"}, 32'(WR_ERR), 32'(0));
        chk({tag, "_output_en"}, 32'(OUTPUT_EN), 32'(0));
    endtask

    task automatic apply_reset(input int d);
        BUS_RST = 1'b1;
        WR_EN = 1'b0; START = 1'b0; STOP = 1'b0;
        EXT_TRIGGER = 1'b0; EXT_START_EN = 1'b0;
        BIT_DIV = 8'(d);
        tick();
        tick();
        check_reset_outputs("reset");
        BUS_RST = 1'b0;
        k = 0;
    endtask

    // Index of the first word boundary at or after index i.
    function automatic int next_bnd(input int i, input int f);
        int b;
        b = i;
        while (b % f != f - 1) b++;
        return b;
    endfunction

    task automatic run_scen(input scen_t sc);
        int d, f, s, b, first, total, stop_at, wr_at, jend, j, t, wsel;
        logic [15:0] wd;
        logic [3:0]  lanes;
        logic ib, db, in_win;
        d = sc.div;
        f = 16 * (d + 1);
        apply_reset(d);
        if (sc.do_write) begin
            WR_EN = 1'b1; WR_ADDR = 8'd0; WR_DATA = sc.w0;
            tick();
            idle_samp(d, 1'b0);
            if (!sc.wws) begin
                WR_ADDR = 8'd1; WR_DATA = sc.w1;
                tick();
                idle_samp(d, 1'b0);
            end
            WR_EN = 1'b0;
        end
        LENGTH = 9'(sc.len); REPEAT = 16'(sc.reps); CH_MASK = sc.mask;
        tick();
        idle_samp(d, 1'b0);
        if (sc.ext) begin
            EXT_START_EN = 1'b1; EXT_TRIGGER = 1'b1;
        end else begin
            START = 1'b1;
        end
        if (sc.wws) begin
            WR_EN = 1'b1; WR_ADDR = 8'd1; WR_DATA = sc.w1;
        end
        tick();
        s = k;
        START = 1'b0; EXT_TRIGGER = 1'b0; EXT_START_EN = 1'b0; WR_EN = 1'b0;
        // Configuration is latched at the start; these must have no effect.
        LENGTH = 9'd0; REPEAT = 16'd7; CH_MASK = ~sc.mask;

        b       = next_bnd(s, f);
        first   = b + f + 2;
        total   = (sc.stop_word >= 0) ? (sc.stop_word + 1) * f : sc.len * sc.reps * f;
        stop_at = (sc.stop_word >= 0) ? first + sc.stop_word * f + f / 2 : -10;
        wr_at   = sc.wr_busy ? first + 3 : -10;
        jend    = first + total + f + 4;

        while (1) begin
            j      = k;
            ib     = idle_bit(j, d);
            in_win = (j >= first) && (j < first + total);
            lanes  = {4{ib}};
            t      = j - first;
            if (in_win) begin
                wsel = (t / f) % sc.len;
                wd   = (wsel != 0) ? sc.w1 : sc.w0;
                db   = wd[15 - ((t / (d + 1)) % 16)];
                for (int i = 0; i < 4; i++) lanes[i] = sc.mask[i] ? db : ib;
            end
            samp(lanes, in_win, in_win && (t % (sc.len * f) == 0),
                 j == first + total, j < first + total, j == wr_at + 1);
            STOP = (j == stop_at - 1);
            if (j == wr_at) begin
                WR_EN = 1'b1; WR_ADDR = 8'd0; WR_DATA = 16'hDEAD;
            end else begin
                WR_EN = 1'b0;
            end
            if (j >= jend) break;
            tick();
        end
        STOP = 1'b0; WR_EN = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int s, b, first;
        tbl[0] = '{16'hAAAA, 16'h1234, 2, 1, 0, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        tbl[1] = '{16'hC3A5, 16'h0000, 1, 3, 3, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        tbl[2] = '{16'h0F0F, 16'hF00F, 2, 2, 1, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, -1};
        tbl[3] = '{16'h5A5A, 16'h9669, 2, 0, 0, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b1, 5};
        tbl[4] = '{16'h5A5A, 16'h9669, 2, 1, 0, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, -1};

        OUT_EN_CFG = 1'b1;
        WR_ADDR = '0; WR_DATA = '0; LENGTH = '0; REPEAT = '0; CH_MASK = 4'b1111;

        // Idle stream after reset.
        apply_reset(0);
        for (int i = 0; i < 40; i++) begin
            tick();
            idle_samp(0, 1'b0);
        end

        // External trigger while disabled: nothing starts.
        LENGTH = 9'd2; REPEAT = 16'd1;
        EXT_START_EN = 1'b0; EXT_TRIGGER = 1'b1;
        tick();
        EXT_TRIGGER = 1'b0;
        idle_samp(0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            idle_samp(0, 1'b0);
        end

        // LENGTH=0: DONE at the next word boundary, lanes stay idle.
        LENGTH = 9'd0;
        START = 1'b1;
        tick();
        START = 1'b0;
        s = k;
        b = next_bnd(s, 16);
        while (k <= b + 20) begin
            samp({4{idle_bit(k, 0)}}, 1'b0, 1'b0, k == b + 1, k <= b, 1'b0);
            tick();
        end

        // START and STOP together: STOP wins.
        LENGTH = 9'd2;
        START = 1'b1; STOP = 1'b1;
        tick();
        START = 1'b0; STOP = 1'b0;
        for (int i = 0; i < 48; i++) begin
            idle_samp(0, 1'b0);
            tick();
        end

        for (int n = 0; n < 5; n++) run_scen(tbl[n]);

        // Reset in the middle of a sequence: immediate abort, no DONE.
        apply_reset(0);
        LENGTH = 9'd2; REPEAT = 16'd0; CH_MASK = 4'b1111;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        s = k;
        b = next_bnd(s, 16);
        first = b + 16 + 2;
        while (k < first + 5) tick();
        chk("writing_before_reset", 32'(WRITING), 32'(1));
        BUS_RST = 1'b1;
        tick();
        check_reset_outputs("midrun_reset");
        BUS_RST = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            idle_samp(0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
